// File: rtl/sp_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_ctrl_pkg
// Description : Shared constants for the single-port SRAM request controller.
//               Holds default field widths, the RDWEN encodings, the macro
//               read latency and a helper for sizing occupancy counters.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_ctrl_pkg;

    // Default request/response field widths
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RSP_DEPTH  = 4;

    // RDWEN encodings seen by the macro
    localparam logic RDWEN_WR = 1'b1;
    localparam logic RDWEN_RD = 1'b0;

    // DO is valid this many cycles after the macro samples a read
    localparam int MACRO_RD_LATENCY = 1;

    // Width of a counter that must represent 0..n inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_rsp_fifo
// Description : Response buffer, DEPTH x WIDTH, with a registered head word.
//               Push and pop in the same cycle are legal at any occupancy.
//               Pointers wrap modulo DEPTH (DEPTH must be a power of 2).
// Revision    : 1.0 - initial release
// Ports       : clk_i    - rising-edge clock
//               rstn_i   - synchronous active-low reset
//               push_i   - write wdata_i into the tail
//               wdata_i  - data to push
//               pop_i    - drop the head word
//               rdata_o  - head word (registered)
//               full_o   - DEPTH entries occupied
//               empty_o  - no entries occupied
// ============================================================================
module sp_ram_rsp_fifo
    import sp_ram_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH,
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] rdata_q,  rdata_d;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = rdata_q;

    // A push into a full buffer is only accepted when the head leaves in
    // the same cycle.
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head register: after a pop the next entry is already in storage
        // when more than one word was held; otherwise the incoming word
        // becomes the head directly.
        if (w_pop) begin
            if (count_q > CNT_W'(1)) begin
                rdata_d = mem_q[rd_ptr_d];
            end else if (w_push) begin
                rdata_d = wdata_i;
            end
        end else if (empty_o && w_push) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_req_ctrl
// Description : Initiator-side controller for one single-port SRAM macro.
//               Turns a valid/ready request stream into registered macro
//               inputs (A, DI, BW, CE, RDWEN) and returns read data on a
//               valid/ready response stream with a fixed 3-cycle
//               accept-to-response latency. A credit counter reserves a
//               response buffer slot for every outstanding read, so
//               response backpressure never stalls the macro.
// Revision    : 1.0 - initial release
// Option      : SP_RAM_REQ_CTRL_WR_ACK_EN - when defined, writes also take a
//               credit and return a zero-data response, ordered with reads.
// Ports       : CLK        - rising-edge clock
//               RSTN       - synchronous active-low reset
//               req_*      - request stream (we, addr, wdata, wmask)
//               rsp_*      - response stream (rdata)
//               A/DI/BW    - macro address, write data, bit-write enable
//               CE/RDWEN   - macro chip enable, 1=write 0=read
//               DO         - macro read data, valid the cycle after a read
// ============================================================================
module sp_ram_req_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] DI,
    output logic [DATA_WIDTH-1:0] BW,
    output logic                  CE,
    output logic                  RDWEN,
    input  logic [DATA_WIDTH-1:0] DO
);

    localparam int               CNT_W      = cnt_width(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RSP_DEPTH);
    // One stage for the macro-input register, then the macro read latency
    localparam int               PIPE_LEN   = MACRO_RD_LATENCY + 1;

    // ------------------------------------------------------------------
    // Request acceptance and credits
    // ------------------------------------------------------------------
    logic             w_req_hs;
    logic             w_rsp_req;
    logic             w_rsp_hs;
    logic             w_credit_avail;
    logic [CNT_W-1:0] credits_q, credits_d;

    // Credits come from a register only, so req_ready never depends on
    // req_valid or rsp_ready.
    assign w_credit_avail = (credits_q < CREDIT_MAX);

`ifdef SP_RAM_REQ_CTRL_WR_ACK_EN
    assign req_ready = RSTN & w_credit_avail;
    assign w_req_hs  = req_valid & req_ready;
    assign w_rsp_req = w_req_hs;
`else
    assign req_ready = RSTN & (req_we | w_credit_avail);
    assign w_req_hs  = req_valid & req_ready;
    assign w_rsp_req = w_req_hs & (req_we == RDWEN_RD);
`endif

    assign w_rsp_hs = rsp_valid & rsp_ready;

    always_comb begin
        credits_d = credits_q;
        case ({w_rsp_req, w_rsp_hs})
            2'b10:   credits_d = credits_q + CNT_W'(1);
            2'b01:   credits_d = credits_q - CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            credits_q <= '0;
        end else begin
            credits_q <= credits_d;
        end
    end

    // ------------------------------------------------------------------
    // Macro input register. A/DI/BW/RDWEN only load on a handshake so the
    // macro pins stay quiet while CE is low.
    // ------------------------------------------------------------------
    logic                  ce_q;
    logic                  rdwen_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] di_q;
    logic [DATA_WIDTH-1:0] bw_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ce_q    <= 1'b0;
            rdwen_q <= RDWEN_RD;
            a_q     <= '0;
            di_q    <= '0;
            bw_q    <= '0;
        end else begin
            ce_q <= w_req_hs;
            if (w_req_hs) begin
                rdwen_q <= req_we ? RDWEN_WR : RDWEN_RD;
                a_q     <= req_addr;
                di_q    <= req_wdata;
                bw_q    <= req_wmask;
            end
        end
    end

    assign CE    = ce_q;
    assign RDWEN = rdwen_q;
    assign A     = a_q;
    assign DI    = di_q;
    assign BW    = bw_q;

    // ------------------------------------------------------------------
    // Response pipe: bit 0 marks a response-producing request sitting in
    // the macro-input register, the last bit marks the cycle DO is valid.
    // ------------------------------------------------------------------
    logic [PIPE_LEN-1:0]   rsp_pipe_q;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rsp_pipe_q <= '0;
        end else begin
            rsp_pipe_q <= {rsp_pipe_q[PIPE_LEN-2:0], w_rsp_req};
        end
    end

    assign w_push = rsp_pipe_q[PIPE_LEN-1];

`ifdef SP_RAM_REQ_CTRL_WR_ACK_EN
    // Tracks which pipe slots are write acknowledgements, whose response
    // data is forced to zero instead of taking DO.
    logic [PIPE_LEN-1:0] wr_pipe_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_pipe_q <= '0;
        end else begin
            wr_pipe_q <= {wr_pipe_q[PIPE_LEN-2:0], w_req_hs & req_we};
        end
    end

    assign w_push_data = wr_pipe_q[PIPE_LEN-1] ? '0 : DO;
`else
    assign w_push_data = DO;
`endif

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    logic w_fifo_full;
    logic w_fifo_empty;

    sp_ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i   (CLK),
        .rstn_i  (RSTN),
        .push_i  (w_push),
        .wdata_i (w_push_data),
        .pop_i   (w_rsp_hs),
        .rdata_o (rsp_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign rsp_valid = ~w_fifo_empty;

    // Credits reserve a slot for every in-flight response, so a push can
    // only meet a full buffer when the head is leaving in the same cycle.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(w_push && w_fifo_full && !w_rsp_hs));

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_req_ctrl
// Description : Self-checking bench for sp_ram_req_ctrl with a behavioural
//               single-port SRAM model. Expected responses are queued when a
//               request is accepted; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_req_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK;
    logic          RSTN;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] A;
    logic [DW-1:0] DI;
    logic [DW-1:0] BW;
    logic          CE;
    logic          RDWEN;
    logic [DW-1:0] DO;

    sp_ram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (4)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .A         (A),
        .DI        (DI),
        .BW        (BW),
        .CE        (CE),
        .RDWEN     (RDWEN),
        .DO        (DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural SRAM macro
    logic [DW-1:0] mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        DO = '0;
    end
    always @(posedge CLK) begin
        if (CE) begin
            if (RDWEN) mem[A] <= (mem[A] & ~BW) | (DI & BW);
            else       DO     <= mem[A];
        end
    end

    // Scoreboard
    typedef struct {
        logic [DW-1:0] data;
        int            acc;
        bit            exact;
    } exp_t;
    exp_t exp_q[$];
    bit   head_seen = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_rdata %h expected no response (cycle %0d)", rsp_rdata, cyc);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].data);
                if (!head_seen) begin
                    head_seen = 1'b1;
                    checks++;
                    if (exp_q[0].exact ? (cyc - exp_q[0].acc != 3) : (cyc - exp_q[0].acc < 3)) begin
                        errors++;
                        $display("FAIL rsp_latency: got %0d cycles expected %s3", cyc - exp_q[0].acc,
                                 exp_q[0].exact ? "" : ">=");
                    end
                end
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one request, wait for acceptance and queue its expected response.
    task automatic send(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input logic [DW-1:0] exp_rd, input bit exact,
                        input int max_wait, output int waited);
        bit done;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        waited    = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (req_ready) begin
                done = 1'b1;
                if (!we) exp_q.push_back('{data: exp_rd, acc: cyc, exact: exact});
`ifdef SP_RAM_REQ_CTRL_WR_ACK_EN
                else exp_q.push_back('{data: '0, acc: cyc, exact: exact});
`endif
            end else begin
                waited++;
                if (waited >= max_wait) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got no accept after %0d cycles expected accept (addr %0d)", waited, addr);
                    done = 1'b1;
                end
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        RSTN      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // Reset held with a pending request
        repeat (3) begin
            @(negedge CLK);
            chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_ce",        {31'b0, CE},        32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        step();
        RSTN = 1'b1;
        send(1'b0, 10'd0, '0, '0, 32'h0, 1'b1, 1, w);
        chk("first_accept_wait", w, 0);
        drain(20);

        // Masked write followed back-to-back by a read of the same word
        send(1'b1, 10'd5, 32'h12345678, 32'hFFFFFFFF, '0, 1'b1, 4, w);
        drain(20);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5;
        req_wdata = 32'hDEADBEEF; req_wmask = 32'hFFFF0000;
        @(negedge CLK);
        chk("raw_wr_ready", {31'b0, req_ready}, 32'd1);
`ifdef SP_RAM_REQ_CTRL_WR_ACK_EN
        exp_q.push_back('{data: '0, acc: cyc, exact: 1'b1});
`endif
        step();
        req_we = 1'b0; req_wdata = '0; req_wmask = '0;
        @(negedge CLK);
        chk("raw_rd_ready", {31'b0, req_ready}, 32'd1);
        exp_q.push_back('{data: 32'hDEAD5678, acc: cyc, exact: 1'b1});
        chk("raw_wr_ce",    {31'b0, CE},    32'd1);
        chk("raw_wr_rdwen", {31'b0, RDWEN}, 32'd1);
        chk("raw_wr_a",     {22'b0, A},     32'd5);
        chk("raw_wr_di",    DI,             32'hDEADBEEF);
        chk("raw_wr_bw",    BW,             32'hFFFF0000);
        step();
        req_valid = 1'b0;
        @(negedge CLK);
        chk("raw_rd_ce",    {31'b0, CE},    32'd1);
        chk("raw_rd_rdwen", {31'b0, RDWEN}, 32'd0);
        chk("raw_rd_a",     {22'b0, A},     32'd5);
        step();
        @(negedge CLK);
        chk("idle_ce",      {31'b0, CE},    32'd0);
        chk("idle_a_hold",  {22'b0, A},     32'd5);
        step();
        drain(20);

        // Preload 0..7 then stream 8 reads
        for (int i = 0; i < 8; i++)
            send(1'b1, AW'(i), 32'hA5A50000 | i, 32'hFFFFFFFF, '0, 1'b1, 4, w);
        drain(20);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, AW'(i), '0, '0, 32'hA5A50000 | i, 1'b1, 1, w);
            chk("stream_wait", w, 0);
        end
        drain(20);

        // Backpressure: credits run out for reads, writes still accepted
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, AW'(i), '0, '0, 32'hA5A50000 | i, 1'b0, 1, w);
            chk("bp_fill_wait", w, 0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd4;
        repeat (2) begin
            @(negedge CLK);
            chk("bp_rd_blocked", {31'b0, req_ready}, 32'd0);
            step();
        end
        req_we = 1'b1; req_addr = 10'd100; req_wdata = 32'h0BAD0BAD; req_wmask = 32'hFFFFFFFF;
        @(negedge CLK);
`ifdef SP_RAM_REQ_CTRL_WR_ACK_EN
        chk("bp_wr_blocked", {31'b0, req_ready}, 32'd0);
`else
        chk("bp_wr_ready",   {31'b0, req_ready}, 32'd1);
`endif
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, 10'd4, '0, '0, 32'hA5A50004, 1'b0, 20, w);
        send(1'b0, 10'd5, '0, '0, 32'hA5A50005, 1'b0, 20, w);
        drain(30);

        // Reset with one buffered and two in-flight reads
        rsp_ready = 1'b0;
        send(1'b0, 10'd1, '0, '0, 32'hA5A50001, 1'b0, 4, w);
        repeat (4) step();
        send(1'b0, 10'd2, '0, '0, 32'hA5A50002, 1'b0, 4, w);
        send(1'b0, 10'd3, '0, '0, 32'hA5A50003, 1'b0, 4, w);
        RSTN = 1'b0;
        exp_q.delete();
        head_seen = 1'b0;
        step();
        step();
        RSTN = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            chk("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        // Credits back at zero: exactly 4 reads fit
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, AW'(i), '0, '0, 32'hA5A50000 | i, 1'b0, 1, w);
            chk("flush_credit_wait", w, 0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd6;
        @(negedge CLK);
        chk("flush_credit_full", {31'b0, req_ready}, 32'd0);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain(20);

        // Alternating writes and reads
        for (int i = 0; i < 4; i++) begin
            send(1'b1, AW'(200 + i), '0 | (32'hC0DE0000 + i), 32'hFFFFFFFF, '0, 1'b1, 4, w);
            send(1'b0, AW'(200 + i), '0, '0, 32'hC0DE0000 + i, 1'b1, 4, w);
        end
        drain(20);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
